// File: rtl/scsa_pipe_adder.sv
// scsa_pipe_adder: registered speculative carry-select adder with a valid/ready
// handshake on both sides and a per-operation exact/approximate mode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (A_i, B_i, Cin_i, exact_i)
//   out_valid/out_ready result handshake (S_o, Co_o, err_o)
//   err_cnt_o           count of erroneous results handed off
//
// Optional: define SCSA_ERRCNT_EN to build the saturating error counter;
// otherwise err_cnt_o is tied to zero.
//
// Each BLK-bit block predicts its carry-in from the previous block alone
// (that block's carry-out assuming carry-in 0). In exact mode a mispredict
// costs one extra cycle in FIX, where the full-width sum is loaded instead.

module scsa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Cin_i,
    input  logic             exact_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S_o,
    output logic             Co_o,
    output logic             err_o,
    output logic [15:0]      err_cnt_o
);

    localparam int NBLK = WIDTH / BLK;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q, exact_q;

    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             err_q, err_d;

    logic             accept;
    logic             out_hs;

    // Speculative and true carry into every block.
    logic [NBLK-1:0]  spec_c;
    logic [NBLK-1:0]  true_c;
    logic [WIDTH-1:0] spec_s;
    logic             spec_co;
    logic             err_spec;
    logic [WIDTH:0]   exact_sum;

    assign spec_c[0] = cin_q;
    assign true_c[0] = cin_q;

    genvar k;
    generate
        for (k = 0; k < NBLK; k++) begin : g_blk
            logic [BLK:0] g0;

            // Block sum without carry-in. Its top bit is the generate term;
            // all-ones low bits mean the block propagates an incoming carry.
            assign g0 = {1'b0, a_q[k*BLK +: BLK]} + {1'b0, b_q[k*BLK +: BLK]};

            assign spec_s[k*BLK +: BLK] = g0[BLK-1:0] + BLK'(spec_c[k]);

            if (k < NBLK - 1) begin : g_mid
                assign spec_c[k+1] = g0[BLK];
                assign true_c[k+1] = g0[BLK] | (&g0[BLK-1:0] & true_c[k]);
            end else begin : g_last
                assign spec_co = g0[BLK] | (&g0[BLK-1:0] & spec_c[k]);
            end
        end
    endgenerate

    assign err_spec  = |(spec_c ^ true_c);
    assign exact_sum = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(cin_q);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        co_d      = co_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (exact_q && err_spec) begin
                    state_d = FIX;
                end else begin
                    s_d     = spec_s;
                    co_d    = spec_co;
                    err_d   = err_spec;
                    state_d = OUT;
                end
            end
            FIX: begin
                s_d     = exact_sum[WIDTH-1:0];
                co_d    = exact_sum[WIDTH];
                err_d   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? CALC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            exact_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            co_q    <= co_d;
            err_q   <= err_d;
            if (accept) begin
                a_q     <= A_i;
                b_q     <= B_i;
                cin_q   <= Cin_i;
                exact_q <= exact_i;
            end
        end
    end

    assign S_o   = s_q;
    assign Co_o  = co_q;
    assign err_o = err_q;

`ifdef SCSA_ERRCNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && err_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt_o = cnt_q;
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_scsa_pipe_adder.sv
// tb_scsa_pipe_adder: scoreboard bench for scsa_pipe_adder.
// Driver pushes expected results on accept; a monitor pops on each new result.

module tb_scsa_pipe_adder;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int M     = (1 << BLK) - 1;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A_i = '0;
    logic [15:0] B_i = '0;
    logic        Cin_i = 1'b0;
    logic        exact_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] S_o;
    logic        Co_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    scsa_pipe_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_i       (A_i),
        .B_i       (B_i),
        .Cin_i     (Cin_i),
        .exact_i   (exact_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S_o       (S_o),
        .Co_o      (Co_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t cur;
    logic prev_v = 1'b0;
    logic rnd_ready = 1'b0;
    int   cnt_model = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic ex);
        exp_t r;
        int ai, bi, ci, sc, tc, ak, bk, ss, sco, e, full;
        ai = int'(a);
        bi = int'(b);
        ci = int'(cin);
        ss = 0;
        sco = 0;
        e = 0;
        for (int k = 0; k < NBLK; k++) begin
            ak = (ai >> (k * BLK)) & M;
            bk = (bi >> (k * BLK)) & M;
            if (k == 0) sc = ci;
            else sc = (((ai >> ((k - 1) * BLK)) & M) + ((bi >> ((k - 1) * BLK)) & M)) >> BLK;
            tc = ((ai & ((1 << (k * BLK)) - 1)) + (bi & ((1 << (k * BLK)) - 1)) + ci) >> (k * BLK);
            if (sc != tc) e = 1;
            ss += ((ak + bk + sc) & M) << (k * BLK);
            if (k == NBLK - 1) sco = (ak + bk + sc) >> BLK;
        end
        full = ai + bi + ci;
        if (ex && e != 0) begin
            r.s  = full[15:0];
            r.co = full[16];
            r.lat = 3;
        end else begin
            r.s  = ss[15:0];
            r.co = sco[0];
            r.lat = 2;
        end
        r.err = (e != 0);
        r.acc = 0;
        return r;
    endfunction

    // Called just after a rising edge. Returns just after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ex, input exp_t e);
        bit done;
        done = 0;
        A_i = a;
        B_i = b;
        Cin_i = cin;
        exact_i = ex;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc + 1;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done && rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout a=%h b=%h in_ready never rose", a, b);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout queue=%0d out_valid=%b need empty/0", sb.size(), out_valid);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops one expected item per new result, checks hold/ready/count.
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
            cnt_model = 0;
        end else begin
`ifdef SCSA_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt_o), 32'(cnt_model));
`else
            chk("err_cnt_zero", 32'(err_cnt_o), 32'h0);
`endif
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output S=%h Co=%b err=%b need none", S_o, Co_o, err_o);
                    cur.s = S_o;
                    cur.co = Co_o;
                    cur.err = err_o;
                end else begin
                    cur = sb.pop_front();
                    tests++;
                    if (S_o !== cur.s || Co_o !== cur.co || err_o !== cur.err) begin
                        fails++;
                        $display("FAIL result S=%h Co=%b err=%b required S=%h Co=%b err=%b",
                                 S_o, Co_o, err_o, cur.s, cur.co, cur.err);
                    end
                    chk("latency", 32'(cyc + 1 - cur.acc), 32'(cur.lat));
                end
            end else if (out_valid) begin
                tests++;
                if (S_o !== cur.s || Co_o !== cur.co || err_o !== cur.err) begin
                    fails++;
                    $display("FAIL hold S=%h Co=%b err=%b required S=%h Co=%b err=%b",
                             S_o, Co_o, err_o, cur.s, cur.co, cur.err);
                end
            end
            if (out_valid) chk("in_ready_out", 32'(in_ready), 32'(out_ready));
            if (out_valid && out_ready && cur.err && cnt_model < 65535) cnt_model = cnt_model + 1;
            prev_v <= out_valid;
        end
    end

    exp_t e;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_S", 32'(S_o), 32'h0);
        chk("rst_Co", 32'(Co_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'h0);
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived results.
        e = '{s: 16'h0003, co: 1'b0, err: 1'b0, lat: 2, acc: 0};
        send(16'h0001, 16'h0001, 1'b1, 1'b0, e);
        e = '{s: 16'h0000, co: 1'b0, err: 1'b1, lat: 2, acc: 0};
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, e);
        e = '{s: 16'h0100, co: 1'b0, err: 1'b1, lat: 3, acc: 0};
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, e);
        e = '{s: 16'hFF00, co: 1'b0, err: 1'b1, lat: 2, acc: 0};
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        e = '{s: 16'h0000, co: 1'b1, err: 1'b1, lat: 3, acc: 0};
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, e);
        wait_drain();
`ifdef SCSA_ERRCNT_EN
        chk("err_cnt_directed", 32'(err_cnt_o), 32'd4);
`endif

        // Backpressure: hold the result, then hand off and accept together.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h1234, 16'h0F0F, 1'b0, 1'b0, model(16'h1234, 16'h0F0F, 1'b0, 1'b0));
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'hABCD, 16'h5432, 1'b1, 1'b1, model(16'hABCD, 16'h5432, 1'b1, 1'b1));
        wait_drain();

        // Reset while an operation is in CALC: no output may appear.
        @(posedge clk);
        #1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, model(16'h00FF, 16'h0001, 1'b0, 1'b1));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_S", 32'(S_o), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        repeat (6) @(negedge clk);
        chk("abort_no_output", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;

        // Randomized traffic with random consumer stalls.
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a, b;
            logic c, x;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'hFFFF - a;
            c = 1'($urandom);
            x = 1'($urandom);
            send(a, b, c, x, model(a, b, c, x));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
